// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode_stage
// Brief    : Registered RV32/RV64 immediate-decode stage with valid/ready
//            flow control, optional 2-entry skid buffer and pipeline flush.
//            Classifies the instruction format and produces the immediate,
//            CSR zimm, PC-relative sum and an illegal-encoding flag.
// Revision : 1.0 - initial release
// ============================================================================
module imm_decode_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_zimm,
    output logic [XLEN-1:0] out_pc_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_FMT_NONE  = 3'd0;
    localparam logic [2:0] c_FMT_I     = 3'd1;
    localparam logic [2:0] c_FMT_S     = 3'd2;
    localparam logic [2:0] c_FMT_B     = 3'd3;
    localparam logic [2:0] c_FMT_U     = 3'd4;
    localparam logic [2:0] c_FMT_J     = 3'd5;
    localparam logic [2:0] c_FMT_CSR   = 3'd6;
    localparam logic [2:0] c_FMT_SHAMT = 3'd7;

    localparam logic [6:0] c_OP_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OP_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] c_OP_STORE    = 7'b0100011;
    localparam logic [6:0] c_OP_OP       = 7'b0110011;
    localparam logic [6:0] c_OP_LUI      = 7'b0110111;
    localparam logic [6:0] c_OP_OP32     = 7'b0111011;
    localparam logic [6:0] c_OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OP_JALR     = 7'b1100111;
    localparam logic [6:0] c_OP_JAL      = 7'b1101111;
    localparam logic [6:0] c_OP_SYSTEM   = 7'b1110011;

    localparam bit c_RV64 = (XLEN == 64);

    // Only RV32 and RV64 datapaths are meaningful.
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    // One buffered entry: everything presented on out_* travels together.
    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      zimm;
        logic [XLEN-1:0] pc_imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    // Sign-extend a 32-bit value from bit 31 to XLEN.
    function automatic logic [XLEN-1:0] f_sext(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    // Zero-extend a 32-bit value to XLEN.
    function automatic logic [XLEN-1:0] f_zext(input logic [31:0] x);
        return XLEN'(x);
    endfunction

    // ------------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_is_shift;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_pc_imm;
    entry_t          w_entry;
    logic            w_in_xfer;
    logic            w_out_xfer;
    entry_t          r_head;

    assign w_opcode   = in_inst[6:0];
    assign w_funct3   = in_inst[14:12];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    // Opcode classification and immediate assembly; illegal forces imm to 0.
    always_comb begin
        w_fmt     = c_FMT_NONE;
        w_illegal = 1'b0;
        w_imm     = '0;
        if (in_inst[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                c_OP_LOAD, c_OP_JALR: begin
                    w_fmt = c_FMT_I;
                    w_imm = f_sext({{20{in_inst[31]}}, in_inst[31:20]});
                end
                c_OP_OP_IMM: begin
                    if (w_is_shift) begin
                        w_fmt = c_FMT_SHAMT;
                        // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one.
                        if (c_RV64) begin
                            w_imm = f_zext({26'd0, in_inst[25:20]});
                        end else begin
                            w_imm = f_zext({27'd0, in_inst[24:20]});
                        end
                    end else begin
                        w_fmt = c_FMT_I;
                        w_imm = f_sext({{20{in_inst[31]}}, in_inst[31:20]});
                    end
                end
                c_OP_OP_IMM32: begin
                    if (!c_RV64) begin
                        w_illegal = 1'b1;
                    end else if (w_is_shift) begin
                        w_fmt = c_FMT_SHAMT;
                        w_imm = f_zext({27'd0, in_inst[24:20]});
                    end else begin
                        w_fmt = c_FMT_I;
                        w_imm = f_sext({{20{in_inst[31]}}, in_inst[31:20]});
                    end
                end
                c_OP_STORE: begin
                    w_fmt = c_FMT_S;
                    w_imm = f_sext({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
                end
                c_OP_BRANCH: begin
                    w_fmt = c_FMT_B;
                    w_imm = f_sext({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                    in_inst[30:25], in_inst[11:8], 1'b0});
                end
                c_OP_LUI, c_OP_AUIPC: begin
                    w_fmt = c_FMT_U;
                    w_imm = f_sext({in_inst[31:12], 12'd0});
                end
                c_OP_JAL: begin
                    w_fmt = c_FMT_J;
                    w_imm = f_sext({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                    in_inst[20], in_inst[30:21], 1'b0});
                end
                c_OP_SYSTEM: begin
                    // funct3 == 0 covers ECALL/EBREAK/xRET: no immediate.
                    if (w_funct3 != 3'b000) begin
                        w_fmt = c_FMT_CSR;
                        w_imm = f_zext({20'd0, in_inst[31:20]});
                    end
                end
                c_OP_OP, c_OP_MISC_MEM: begin
                    w_fmt = c_FMT_NONE;
                end
                c_OP_OP32: begin
                    w_illegal = !c_RV64;
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
        if (w_illegal) begin
            w_fmt = c_FMT_NONE;
            w_imm = '0;
        end
    end

    // Illegal entries carry imm = 0, so the sum degenerates to pc.
    assign w_pc_imm = in_pc + w_imm;

    assign w_entry = '{
        inst:    in_inst,
        pc:      in_pc,
        imm:     w_imm,
        zimm:    in_inst[19:15],
        pc_imm:  w_pc_imm,
        fmt:     w_fmt,
        illegal: w_illegal
    };

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // ------------------------------------------------------------------------
    // Output buffering
    // ------------------------------------------------------------------------
    if (SKID) begin : g_skid
        typedef enum logic [1:0] {
            S_EMPTY = 2'd0,
            S_ONE   = 2'd1,
            S_FULL  = 2'd2
        } state_t;

        state_t r_state;
        state_t w_state_next;
        entry_t r_tail;

        // Ready and valid come straight from the state register, so there is
        // no combinational path from out_ready to in_ready.
        assign in_ready  = (r_state != S_FULL);
        assign out_valid = (r_state != S_EMPTY);

        // Occupancy state register.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= S_EMPTY;
            end else begin
                r_state <= w_state_next;
            end
        end

        // Occupancy next-state from the two handshakes; flush empties.
        always_comb begin
            w_state_next = r_state;
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_next = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        w_state_next = S_FULL;
                    end else if (w_out_xfer && !w_in_xfer) begin
                        w_state_next = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_xfer) begin
                        w_state_next = S_ONE;
                    end
                end
                default: begin
                    w_state_next = S_EMPTY;
                end
            endcase
            if (flush) begin
                w_state_next = S_EMPTY;
            end
        end

        // Head/tail payload; flush leaves payload untouched, reset clears it.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_head <= '0;
                r_tail <= '0;
            end else if (!flush) begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_in_xfer) begin
                            r_head <= w_entry;
                        end
                    end
                    S_ONE: begin
                        if (w_in_xfer && w_out_xfer) begin
                            r_head <= w_entry;
                        end else if (w_in_xfer) begin
                            r_tail <= w_entry;
                        end
                    end
                    S_FULL: begin
                        if (w_out_xfer) begin
                            r_head <= r_tail;
                        end
                    end
                    default: begin
                        r_head <= r_head;
                    end
                endcase
            end
        end
    end else begin : g_single
        logic r_valid;

        assign out_valid = r_valid;
        assign in_ready  = !r_valid || out_ready;

        // Single slot: a new entry overwrites the slot, a drain clears valid.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_head  <= '0;
            end else if (flush) begin
                r_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_valid <= 1'b1;
                r_head  <= w_entry;
            end else if (w_out_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_inst    = r_head.inst;
    assign out_pc      = r_head.pc;
    assign out_imm     = r_head.imm;
    assign out_zimm    = r_head.zimm;
    assign out_pc_imm  = r_head.pc_imm;
    assign out_fmt     = r_head.fmt;
    assign out_illegal = r_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_decode_stage
// Brief    : Self-checking bench for imm_decode_stage. Three instances
//            (RV32 skid, RV64 skid, RV64 single-slot) share one stimulus
//            stream and are compared against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    always #5 clk = ~clk;

    // RV32, skid buffer
    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_inst, a_out_pc, a_out_imm, a_out_pc_imm;
    logic [4:0]  a_out_zimm;
    logic [2:0]  a_out_fmt;
    // RV64, skid buffer
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_out_inst;
    logic [63:0] b_out_pc, b_out_imm, b_out_pc_imm;
    logic [4:0]  b_out_zimm;
    logic [2:0]  b_out_fmt;
    // RV64, single slot
    logic        c_in_ready, c_out_valid, c_out_illegal;
    logic [31:0] c_out_inst;
    logic [63:0] c_out_pc, c_out_imm, c_out_pc_imm;
    logic [4:0]  c_out_zimm;
    logic [2:0]  c_out_fmt;

    imm_decode_stage #(.XLEN(32), .SKID(1'b1)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_inst(a_out_inst), .out_pc(a_out_pc), .out_imm(a_out_imm), .out_zimm(a_out_zimm),
        .out_pc_imm(a_out_pc_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .SKID(1'b1)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_inst(b_out_inst), .out_pc(b_out_pc), .out_imm(b_out_imm), .out_zimm(b_out_zimm),
        .out_pc_imm(b_out_pc_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .SKID(1'b0)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_inst(c_out_inst), .out_pc(c_out_pc), .out_imm(c_out_imm), .out_zimm(c_out_zimm),
        .out_pc_imm(c_out_pc_imm), .out_fmt(c_out_fmt), .out_illegal(c_out_illegal)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } item_t;

    item_t q1[$];   // expected contents of the skid instances
    item_t q0[$];   // expected contents of the single-slot instance

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the encoding rules with plain arithmetic.
    function automatic void ref_decode(input logic [31:0] inst, input logic [63:0] pc, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output logic ill, output logic [63:0] pc_imm);
        longint      sw, hi, mid;
        logic [63:0] mask;
        logic [2:0]  f3;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        sw   = $signed(inst);
        hi   = sw >>> 31;
        f3   = inst[14:12];
        imm  = 0;
        fmt  = 0;
        ill  = 0;
        if (inst[1:0] != 2'b11) begin
            ill = 1;
        end else begin
            case (inst[6:0])
                7'h03, 7'h67: begin fmt = 1; mid = sw >>> 20; imm = mid; end
                7'h13: begin
                    if (f3 == 1 || f3 == 5) begin fmt = 7; imm = (inst >> 20) % xlen; end
                    else begin fmt = 1; mid = sw >>> 20; imm = mid; end
                end
                7'h1B: begin
                    if (xlen != 64) ill = 1;
                    else if (f3 == 1 || f3 == 5) begin fmt = 7; imm = (inst >> 20) % 32; end
                    else begin fmt = 1; mid = sw >>> 20; imm = mid; end
                end
                7'h23: begin fmt = 2; mid = sw >>> 25; imm = mid * 32 + inst[11:7]; end
                7'h63: begin
                    fmt = 3;
                    imm = hi * 4096 + inst[7] * 2048 + inst[30:25] * 32 + inst[11:8] * 2;
                end
                7'h37, 7'h17: begin fmt = 4; mid = sw >>> 12; imm = mid * 4096; end
                7'h6F: begin
                    fmt = 5;
                    imm = hi * (64'd1 << 20) + inst[19:12] * 4096 + inst[20] * 2048 + inst[30:21] * 2;
                end
                7'h73: if (f3 != 0) begin fmt = 6; imm = inst >> 20; end
                7'h33, 7'h0F: fmt = 0;
                7'h3B: if (xlen != 64) ill = 1;
                default: ill = 1;
            endcase
        end
        if (ill) begin
            imm = 0;
            fmt = 0;
        end
        imm    = imm & mask;
        pc_imm = (pc + imm) & mask;
    endfunction

    task automatic check_dut(input string nm, input int xlen, input bit has, input item_t it,
                             input logic ov, input logic [31:0] oinst, input logic [63:0] opc,
                             input logic [63:0] oimm, input logic [4:0] oz, input logic [63:0] opcimm,
                             input logic [2:0] ofmt, input logic oill);
        logic [63:0] e_imm, e_pcimm, mask;
        logic [2:0]  e_fmt;
        logic        e_ill;
        check({nm, " out_valid"}, ov, has);
        if (has) begin
            mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
            ref_decode(it.inst, it.pc & mask, xlen, e_imm, e_fmt, e_ill, e_pcimm);
            check({nm, " inst"}, oinst, it.inst);
            check({nm, " pc"}, opc, it.pc & mask);
            check({nm, " imm"}, oimm, e_imm);
            check({nm, " fmt"}, ofmt, e_fmt);
            check({nm, " illegal"}, oill, e_ill);
            if (e_fmt == 6)
                check({nm, " zimm"}, oz, it.inst[19:15]);
            if (e_ill || e_fmt == 3 || e_fmt == 5 || it.inst[6:0] == 7'h17)
                check({nm, " pc_imm"}, opcimm, e_pcimm);
        end
    endtask

    task automatic check_all();
        item_t h1, h0;
        h1.inst = '0; h1.pc = '0;
        h0 = h1;
        if (q1.size() > 0) h1 = q1[0];
        if (q0.size() > 0) h0 = q0[0];
        check_dut("a", 32, q1.size() > 0, h1, a_out_valid, a_out_inst, a_out_pc, a_out_imm,
                  a_out_zimm, a_out_pc_imm, a_out_fmt, a_out_illegal);
        check_dut("b", 64, q1.size() > 0, h1, b_out_valid, b_out_inst, b_out_pc, b_out_imm,
                  b_out_zimm, b_out_pc_imm, b_out_fmt, b_out_illegal);
        check_dut("c", 64, q0.size() > 0, h0, c_out_valid, c_out_inst, c_out_pc, c_out_imm,
                  c_out_zimm, c_out_pc_imm, c_out_fmt, c_out_illegal);
    endtask

    // One clock of stimulus: drive, check ready, advance the model, check outputs.
    task automatic step(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                        input bit ordy, input bit fl);
        item_t it;
        bit rdy1, rdy0, i1, o1, i0, o0;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        rdy1 = (q1.size() < 2);
        rdy0 = (q0.size() == 0) || ordy;
        check("a in_ready", a_in_ready, rdy1);
        check("b in_ready", b_in_ready, rdy1);
        check("c in_ready", c_in_ready, rdy0);
        it.inst = inst;
        it.pc   = pc;
        i1 = v && rdy1;
        o1 = (q1.size() > 0) && ordy;
        i0 = v && rdy0;
        o0 = (q0.size() > 0) && ordy;
        if (fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (o1) void'(q1.pop_front());
            if (i1) q1.push_back(it);
            if (o0) void'(q0.pop_front());
            if (i0) q0.push_back(it);
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Reset (with flush also asserted) must clear everything to zero.
    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_inst   = $urandom;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        q1.delete();
        q0.delete();
        #1;
        check("a rst ctl", {a_out_valid, a_out_zimm, a_out_fmt, a_out_illegal, a_in_ready}, 64'd1);
        check("a rst inst/pc", {a_out_inst, a_out_pc}, 64'd0);
        check("a rst imm/pc_imm", {a_out_imm, a_out_pc_imm}, 64'd0);
        check("b rst ctl", {b_out_valid, b_out_zimm, b_out_fmt, b_out_illegal, b_in_ready}, 64'd1);
        check("b rst inst", b_out_inst, 64'd0);
        check("b rst pc", b_out_pc, 64'd0);
        check("b rst imm", b_out_imm, 64'd0);
        check("b rst pc_imm", b_out_pc_imm, 64'd0);
        check("c rst ctl", {c_out_valid, c_out_zimm, c_out_fmt, c_out_illegal, c_in_ready}, 64'd1);
        check("c rst inst", c_out_inst, 64'd0);
        check("c rst pc", c_out_pc, 64'd0);
        check("c rst imm", c_out_imm, 64'd0);
        check("c rst pc_imm", c_out_pc_imm, 64'd0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 15))
            0:  op = 7'h03;
            1:  op = 7'h13;
            2:  op = 7'h1B;
            3:  op = 7'h23;
            4:  op = 7'h63;
            5:  op = 7'h37;
            6:  op = 7'h17;
            7:  op = 7'h6F;
            8:  op = 7'h67;
            9:  op = 7'h73;
            10: op = 7'h33;
            11: op = 7'h3B;
            12: op = 7'h0F;
            default: op = r[6:0];
        endcase
        return {r[31:7], op};
    endfunction

    localparam logic [31:0] c_A = 32'h0010_0093;
    localparam logic [31:0] c_B = 32'h0020_0113;
    localparam logic [31:0] c_C = 32'h0030_0193;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        do_reset();

        // Directed decode vectors
        step(1'b1, 32'hFE00_0EE3, 64'h1000, 1'b1, 1'b0);
        check("branch fmt", a_out_fmt, 64'd3);
        check("branch imm", a_out_imm, 64'hFFFF_FFFC);
        check("branch pc_imm", a_out_pc_imm, 64'h0000_0FFC);
        step(1'b1, 32'h8000_02B7, 64'h0, 1'b1, 1'b0);
        check("lui64 imm", b_out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui64 fmt", b_out_fmt, 64'd4);
        step(1'b1, 32'h03F2_9293, 64'h0, 1'b1, 1'b0);
        check("slli64 fmt", b_out_fmt, 64'd7);
        check("slli64 imm", b_out_imm, 64'd63);
        check("slli32 imm", a_out_imm, 64'd31);
        step(1'b1, 32'h0000_0000, 64'h40, 1'b1, 1'b0);
        check("zero illegal", a_out_illegal, 64'd1);
        check("zero fmt", a_out_fmt, 64'd0);
        check("zero imm", a_out_imm, 64'd0);
        check("zero pc_imm", a_out_pc_imm, 64'h40);
        step(1'b1, 32'h3002_D073, 64'h80, 1'b1, 1'b0);
        check("csrrwi fmt", a_out_fmt, 64'd6);
        check("csrrwi imm", a_out_imm, 64'h300);
        check("csrrwi zimm", a_out_zimm, 64'd5);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Backpressure: A, B fill the skid buffer; C must wait.
        step(1'b1, c_A, 64'h100, 1'b0, 1'b0);
        step(1'b1, c_B, 64'h104, 1'b0, 1'b0);
        check("bp ready drop", a_in_ready, 64'd0);
        step(1'b1, c_C, 64'h108, 1'b0, 1'b0);
        check("bp head A", a_out_inst, c_A);
        step(1'b1, c_C, 64'h108, 1'b1, 1'b0);
        check("bp head B", a_out_inst, c_B);
        step(1'b1, c_C, 64'h108, 1'b1, 1'b0);
        check("bp head C", a_out_inst, c_C);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        check("bp drained", a_out_valid, 64'd0);

        // Flush with a full buffer and a simultaneous input.
        step(1'b1, c_A, 64'h200, 1'b0, 1'b0);
        step(1'b1, c_B, 64'h204, 1'b0, 1'b0);
        step(1'b1, c_C, 64'h208, 1'b0, 1'b1);
        check("flush valid", a_out_valid, 64'd0);
        check("flush ready", a_in_ready, 64'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Randomized traffic against the reference queues.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 70, rand_inst(), {$urandom, $urandom},
                     $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
